// File: rtl/addsub_operand_seq_pkg.sv
// Shared definitions for the add/sub operand sequencer: FSM state encoding
// and the add/subtract mode selectors.
package addsub_operand_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        EXEC  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int MODE_ADD = 1;
    localparam int MODE_SUB = 0;

endpackage

// File: rtl/addsub_operand_seq_core.sv
// Combinational add/sub datapath; the top bit of res is carry (add) or borrow (sub).
module addsub_core
    import addsub_operand_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_ADD
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   res
);

    // At WIDTH+1 bits the subtract wraps negative exactly when a < b unsigned.
    generate
        if (MODE == MODE_ADD) begin : g_add
            assign res = {1'b0, a} + {1'b0, b};
        end else begin : g_sub
            assign res = {1'b0, a} - {1'b0, b};
        end
    endgenerate

endmodule

// File: rtl/addsub_operand_seq.sv
// Collects two serial operands, registers the add/sub result with its flag,
// and holds it until downstream accepts; counts completed operations.
module addsub_operand_seq
    import addsub_operand_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_ADD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       op_count
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic             valid_q, valid_d;
    logic [7:0]       count_q, count_d;
    logic [WIDTH:0]   core_res;

    addsub_core #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_core (
        .a   (a_q),
        .b   (b_q),
        .res (core_res)
    );

    assign in_ready   = (state_q == IDLE) || (state_q == GOT_A);
    assign out_result = result_q;
    assign out_flag   = flag_q;
    assign out_valid  = valid_q;
    assign op_count   = count_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flag_d   = flag_q;
        valid_d  = valid_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_data;
                    state_d = GOT_A;
                end
            end
            GOT_A: begin
                if (in_valid) begin
                    b_d     = in_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = core_res[WIDTH-1:0];
                flag_d   = core_res[WIDTH];
                valid_d  = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                // Result and flag stay registered after the handshake; only valid drops.
                if (out_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_addsub_operand_seq.sv
// Directed bench for addsub_operand_seq: one subtract instance and one add instance
// sharing clock and reset.
module tb_addsub_operand_seq;

    logic       clk;
    logic       rst;

    logic [3:0] s_in_data;
    logic       s_in_valid;
    logic       s_in_ready;
    logic [3:0] s_out_result;
    logic       s_out_flag;
    logic       s_out_valid;
    logic       s_out_ready;
    logic [7:0] s_op_count;

    logic [3:0] a_in_data;
    logic       a_in_valid;
    logic       a_in_ready;
    logic [3:0] a_out_result;
    logic       a_out_flag;
    logic       a_out_valid;
    logic       a_out_ready;
    logic [7:0] a_op_count;

    int checks;
    int errors;

    addsub_operand_seq #(.WIDTH(4), .MODE(0)) u_sub (
        .clk        (clk),
        .rst        (rst),
        .in_data    (s_in_data),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .out_result (s_out_result),
        .out_flag   (s_out_flag),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .op_count   (s_op_count)
    );

    addsub_operand_seq #(.WIDTH(4), .MODE(1)) u_add (
        .clk        (clk),
        .rst        (rst),
        .in_data    (a_in_data),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .out_result (a_out_result),
        .out_flag   (a_out_flag),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .op_count   (a_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic s_send(input logic [3:0] w);
        s_in_data  = w;
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
    endtask

    task automatic a_send(input logic [3:0] w);
        a_in_data  = w;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
    endtask

    function automatic logic [3:0] op_a(input int k);
        logic [31:0] v;
        v = k;
        return v[3:0];
    endfunction

    function automatic logic [3:0] op_b(input int k);
        logic [31:0] v;
        v = k * 5 + 3;
        return v[3:0];
    endfunction

    initial begin
        logic [4:0] exp_sum;
        int         w_idx;
        int         done_ops;
        logic       accepted;

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        s_in_data   = 4'h0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        a_in_data   = 4'h0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check_output("reset_s_valid", {31'd0, s_out_valid}, 32'd0);
        check_output("reset_s_result", {28'd0, s_out_result}, 32'd0);
        check_output("reset_s_flag", {31'd0, s_out_flag}, 32'd0);
        check_output("reset_s_count", {24'd0, s_op_count}, 32'd0);
        check_output("reset_s_in_ready", {31'd0, s_in_ready}, 32'd1);
        check_output("reset_a_valid", {31'd0, a_out_valid}, 32'd0);
        check_output("reset_a_count", {24'd0, a_op_count}, 32'd0);

        // 6 - 2
        s_send(4'b0110);
        s_send(4'b0010);
        check_output("sub1_valid_early", {31'd0, s_out_valid}, 32'd0);
        tick();
        check_output("sub1_valid", {31'd0, s_out_valid}, 32'd1);
        check_output("sub1_result", {28'd0, s_out_result}, 32'h4);
        check_output("sub1_flag", {31'd0, s_out_flag}, 32'd0);
        check_output("sub1_in_ready", {31'd0, s_in_ready}, 32'd0);
        tick();
        check_output("sub1_valid_drop", {31'd0, s_out_valid}, 32'd0);
        check_output("sub1_count", {24'd0, s_op_count}, 32'd1);
        check_output("sub1_idle_ready", {31'd0, s_in_ready}, 32'd1);

        // 2 - 6 borrows
        s_send(4'b0010);
        s_send(4'b0110);
        tick();
        check_output("sub2_valid", {31'd0, s_out_valid}, 32'd1);
        check_output("sub2_result", {28'd0, s_out_result}, 32'hc);
        check_output("sub2_flag", {31'd0, s_out_flag}, 32'd1);
        tick();
        check_output("sub2_count", {24'd0, s_op_count}, 32'd2);

        // 9 + 8 carries, then is held off by downstream for 5 cycles
        a_send(4'b1001);
        a_send(4'b1000);
        check_output("add_valid_early", {31'd0, a_out_valid}, 32'd0);
        tick();
        check_output("add_valid", {31'd0, a_out_valid}, 32'd1);
        check_output("add_result", {28'd0, a_out_result}, 32'h1);
        check_output("add_flag", {31'd0, a_out_flag}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            a_in_data  = 4'hf;
            a_in_valid = 1'b1;
            tick();
            a_in_valid = 1'b0;
            check_output("bp_valid", {31'd0, a_out_valid}, 32'd1);
            check_output("bp_result", {28'd0, a_out_result}, 32'h1);
            check_output("bp_flag", {31'd0, a_out_flag}, 32'd1);
            check_output("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
            check_output("bp_count", {24'd0, a_op_count}, 32'd0);
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check_output("bp_release_valid", {31'd0, a_out_valid}, 32'd0);
        check_output("bp_release_count", {24'd0, a_op_count}, 32'd1);
        check_output("bp_release_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        check_output("bp_single_xfer", {24'd0, a_op_count}, 32'd1);

        // Reset after A is captured drops the pending operand
        a_send(4'b0111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("midrst_count", {24'd0, a_op_count}, 32'd0);
        check_output("midrst_ready", {31'd0, a_in_ready}, 32'd1);
        check_output("midrst_valid", {31'd0, a_out_valid}, 32'd0);
        a_out_ready = 1'b1;
        a_send(4'b0011);
        a_send(4'b0001);
        tick();
        check_output("midrst_valid_res", {31'd0, a_out_valid}, 32'd1);
        check_output("midrst_result", {28'd0, a_out_result}, 32'h4);
        check_output("midrst_flag", {31'd0, a_out_flag}, 32'd0);
        tick();
        check_output("midrst_count_after", {24'd0, a_op_count}, 32'd1);

        // 256 back-to-back operations with in_valid held high throughout
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("wrap_start_count", {24'd0, a_op_count}, 32'd0);
        w_idx       = 0;
        done_ops    = 0;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 1200 && done_ops < 256; cyc++) begin
            a_in_data = (w_idx % 2 == 0) ? op_a(w_idx / 2) : op_b(w_idx / 2);
            accepted  = a_in_ready;
            if (a_out_valid) begin
                exp_sum = {1'b0, op_a(done_ops)} + {1'b0, op_b(done_ops)};
                check_output("wrap_result", {28'd0, a_out_result}, {28'd0, exp_sum[3:0]});
                check_output("wrap_flag", {31'd0, a_out_flag}, {31'd0, exp_sum[4]});
                done_ops++;
            end
            tick();
            if (accepted) w_idx++;
        end
        a_in_valid = 1'b0;
        check_output("wrap_ops_done", done_ops, 32'd256);
        check_output("wrap_count", {24'd0, a_op_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
